uart_rx_ctrl: RTL and testbench

Controller between the APB register bank and the uart_rx core. It sequences the core's enable and soft-reset and captures each received character into a small show-ahead holding FIFO for APB reads. It also tracks sticky overrun and framing-error flags and raises a level-based interrupt.

---
 rtl/uart_rx_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: sequences the uart_rx core's enable and soft reset, captures
// received characters into a show-ahead holding FIFO, keeps sticky overrun
// and framing-error flags and drives a registered level interrupt.
// Optional feature macro: UART_RX_ERR_FIFO_EN. When defined, errored
// characters are stored with an error tag instead of being discarded.
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2,
  parameter int RST_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_enable,
  input  logic                 cfg_flush,
  input  logic                 err_clr,
  input  logic [FIFO_AW:0]     irq_thresh,
  output logic                 core_rx_en,
  output logic                 core_rx_rst,
  input  logic                 core_rx_done,
  input  logic                 core_rx_busy,
  input  logic                 core_rx_error,
  input  logic [DATA_BITS-1:0] core_rx_data,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_err,
  output logic                 rx_empty,
  output logic                 rx_full,
  output logic [FIFO_AW:0]     rx_level,
  output logic                 overrun,
  output logic                 frame_err,
  output logic                 irq
);

  localparam logic [1:0] S_IDLE       = 2'd0;
  localparam logic [1:0] S_RESET_CORE = 2'd1;
  localparam logic [1:0] S_RUN        = 2'd2;
  localparam logic [1:0] S_DRAIN      = 2'd3;

  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0]      CNT_LAST   = CW'(RST_CYCLES - 1);
  localparam logic [FIFO_AW:0]   LEVEL_FULL = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0]   LEVEL_ONE  = (FIFO_AW + 1)'(1);

  logic [1:0]           state;
  logic [1:0]           state_next;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_next;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr;
  logic [FIFO_AW-1:0]   rd_ptr;

  logic                 capture;
  logic                 store_char;
  logic                 do_push;
  logic                 do_pop;
  logic                 ovr_set;
  logic                 fe_set;
  logic [FIFO_AW:0]     level_next;
  logic                 overrun_next;
  logic                 frame_err_next;
  logic [FIFO_AW:0]     thresh_eff;
  logic                 irq_next;

  assign rx_empty = (rx_level == '0);
  assign rx_full  = (rx_level == LEVEL_FULL);

  // Characters are only accepted while the core is actually enabled.
  assign capture = core_rx_done && ((state == S_RUN) || (state == S_DRAIN));

`ifdef UART_RX_ERR_FIFO_EN
  assign store_char = capture;
`else
  assign store_char = capture && !core_rx_error;
`endif

  // A push into a full FIFO is only legal when a pop frees a slot the same cycle.
  assign do_pop  = rd_en && !rx_empty && !cfg_flush;
  assign do_push = store_char && (!rx_full || rd_en) && !cfg_flush;
  assign ovr_set = store_char && rx_full && !rd_en;
  assign fe_set  = capture && core_rx_error;

  // Next-cycle level and sticky flags, shared by the registers and the irq.
  always_comb begin
    level_next = rx_level;
    if (cfg_flush) begin
      level_next = '0;
    end else begin
      level_next = rx_level + (FIFO_AW + 1)'(do_push) - (FIFO_AW + 1)'(do_pop);
    end
    overrun_next   = ovr_set || (overrun && !err_clr);
    frame_err_next = fe_set || (frame_err && !err_clr);
    thresh_eff     = (irq_thresh == '0) ? LEVEL_ONE : irq_thresh;
    irq_next       = (level_next >= thresh_eff) || overrun_next || frame_err_next;
  end

  // Control FSM: a flush overrides every other transition and restarts the core.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (cfg_enable) begin
          state_next = S_RESET_CORE;
          cnt_next   = '0;
        end
      end
      S_RESET_CORE: begin
        if (cnt == CNT_LAST) begin
          state_next = cfg_enable ? S_RUN : S_IDLE;
        end else begin
          cnt_next = cnt + CW'(1);
        end
      end
      S_RUN: begin
        if (!cfg_enable) begin
          state_next = core_rx_busy ? S_DRAIN : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (cfg_enable) begin
          state_next = S_RUN;
        end else if (!core_rx_busy) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
    if (cfg_flush) begin
      state_next = cfg_enable ? S_RESET_CORE : S_IDLE;
      cnt_next   = '0;
    end
  end

  // State, core controls, FIFO bookkeeping, sticky flags and irq registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      core_rx_en  <= 1'b0;
      core_rx_rst <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rx_level    <= '0;
      overrun     <= 1'b0;
      frame_err   <= 1'b0;
      irq         <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      core_rx_en  <= (state_next == S_RUN) || (state_next == S_DRAIN);
      core_rx_rst <= (state_next == S_RESET_CORE);
      if (cfg_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + FIFO_AW'(1);
        if (do_pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      rx_level    <= level_next;
      overrun     <= overrun_next;
      frame_err   <= frame_err_next;
      irq         <= irq_next;
    end
  end

  // Storage array needs no reset; validity is tracked by the level counter.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      mem[wr_ptr] <= core_rx_data;
    end
  end

  assign rd_data = rx_empty ? '0 : mem[rd_ptr];

`ifdef UART_RX_ERR_FIFO_EN
  logic tag_mem [FIFO_DEPTH];

  // Error tags travel alongside their characters.
  always_ff @(posedge clk) begin
    if (!rst && do_push) begin
      tag_mem[wr_ptr] <= core_rx_error;
    end
  end

  assign rd_err = rx_empty ? 1'b0 : tag_mem[rd_ptr];
`else
  assign rd_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Testbench for uart_rx_ctrl: directed scenarios followed by randomized
// traffic, every cycle compared against a queue-based behavioural model.
module tb_uart_rx_ctrl;

  localparam int DATA_BITS  = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = 2;
  localparam int RST_CYCLES = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RESET = 1;
  localparam int M_RUN   = 2;
  localparam int M_DRAIN = 3;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 cfg_enable = 1'b0;
  logic                 cfg_flush = 1'b0;
  logic                 err_clr = 1'b0;
  logic [FIFO_AW:0]     irq_thresh = '0;
  logic                 core_rx_en;
  logic                 core_rx_rst;
  logic                 core_rx_done = 1'b0;
  logic                 core_rx_busy = 1'b0;
  logic                 core_rx_error = 1'b0;
  logic [DATA_BITS-1:0] core_rx_data = '0;
  logic                 rd_en = 1'b0;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_err;
  logic                 rx_empty;
  logic                 rx_full;
  logic [FIFO_AW:0]     rx_level;
  logic                 overrun;
  logic                 frame_err;
  logic                 irq;

  int check_count = 0;
  int fail_count  = 0;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } entry_t;

  entry_t m_q[$];
  int     m_mode = M_IDLE;
  int     m_rst_left = 0;
  logic   m_ovr = 1'b0;
  logic   m_fe  = 1'b0;
  logic   m_irq = 1'b0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(
    .DATA_BITS(DATA_BITS), .FIFO_DEPTH(FIFO_DEPTH),
    .FIFO_AW(FIFO_AW), .RST_CYCLES(RST_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .cfg_enable(cfg_enable), .cfg_flush(cfg_flush),
    .err_clr(err_clr), .irq_thresh(irq_thresh), .core_rx_en(core_rx_en),
    .core_rx_rst(core_rx_rst), .core_rx_done(core_rx_done),
    .core_rx_busy(core_rx_busy), .core_rx_error(core_rx_error),
    .core_rx_data(core_rx_data), .rd_en(rd_en), .rd_data(rd_data),
    .rd_err(rd_err), .rx_empty(rx_empty), .rx_full(rx_full),
    .rx_level(rx_level), .overrun(overrun), .frame_err(frame_err), .irq(irq)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // Reference model: advance one clock using current inputs and model state.
  task automatic modelStep();
    bit     receiving;
    bit     keep;
    bit     full_now;
    int     th;
    entry_t e;
    if (rst) begin
      m_q.delete();
      m_mode = M_IDLE;
      m_rst_left = 0;
      m_ovr = 1'b0;
      m_fe  = 1'b0;
      m_irq = 1'b0;
      return;
    end
    receiving = core_rx_done && (m_mode == M_RUN || m_mode == M_DRAIN);
`ifdef UART_RX_ERR_FIFO_EN
    keep = receiving;
`else
    keep = receiving && !core_rx_error;
`endif
    full_now = (m_q.size() == FIFO_DEPTH);
    m_ovr = (keep && full_now && !rd_en) || (m_ovr && !err_clr);
    m_fe  = (receiving && core_rx_error) || (m_fe && !err_clr);

    if (cfg_flush) begin
      m_q.delete();
    end else begin
      if (rd_en && m_q.size() > 0) void'(m_q.pop_front());
      if (keep && m_q.size() < FIFO_DEPTH) begin
        e.data = core_rx_data;
        e.err  = core_rx_error;
        m_q.push_back(e);
      end
    end

    if (cfg_flush) begin
      if (cfg_enable) begin
        m_mode = M_RESET;
        m_rst_left = RST_CYCLES;
      end else begin
        m_mode = M_IDLE;
      end
    end else begin
      case (m_mode)
        M_IDLE:
          if (cfg_enable) begin
            m_mode = M_RESET;
            m_rst_left = RST_CYCLES;
          end
        M_RESET:
          if (m_rst_left == 1) m_mode = cfg_enable ? M_RUN : M_IDLE;
          else m_rst_left--;
        M_RUN:
          if (!cfg_enable) m_mode = core_rx_busy ? M_DRAIN : M_IDLE;
        default:
          if (cfg_enable) m_mode = M_RUN;
          else if (!core_rx_busy) m_mode = M_IDLE;
      endcase
    end

    th = (irq_thresh == 0) ? 1 : int'(irq_thresh);
    m_irq = (m_q.size() >= th) || m_ovr || m_fe;
  endtask

  task automatic checkAll();
    logic [7:0] exp_data;
    logic       exp_err;
    exp_data = (m_q.size() > 0) ? m_q[0].data : 8'h00;
    exp_err  = (m_q.size() > 0) ? m_q[0].err : 1'b0;
    checkOutput("core_rx_en",  32'(core_rx_en),  32'(m_mode == M_RUN || m_mode == M_DRAIN));
    checkOutput("core_rx_rst", 32'(core_rx_rst), 32'(m_mode == M_RESET));
    checkOutput("rx_level",    32'(rx_level),    32'(m_q.size()));
    checkOutput("rx_empty",    32'(rx_empty),    32'(m_q.size() == 0));
    checkOutput("rx_full",     32'(rx_full),     32'(m_q.size() == FIFO_DEPTH));
    checkOutput("rd_data",     32'(rd_data),     32'(exp_data));
    checkOutput("rd_err",      32'(rd_err),      32'(exp_err));
    checkOutput("overrun",     32'(overrun),     32'(m_ovr));
    checkOutput("frame_err",   32'(frame_err),   32'(m_fe));
    checkOutput("irq",         32'(irq),         32'(m_irq));
  endtask

  // One clock of stimulus: model, edge, compare, then drop the pulses.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    checkAll();
    rst           = 1'b0;
    cfg_flush     = 1'b0;
    err_clr       = 1'b0;
    core_rx_done  = 1'b0;
    core_rx_error = 1'b0;
    rd_en         = 1'b0;
  endtask

  task automatic pushByte(input logic [7:0] d, input logic err, input logic pop);
    core_rx_done  = 1'b1;
    core_rx_data  = d;
    core_rx_error = err;
    rd_en         = pop;
    applyStimulus();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  initial begin
    // Reset, then enable: core reset pulse then RUN.
    rst = 1'b1;
    applyStimulus();
    checkOutput("reset_level", 32'(rx_level), 32'd0);
    checkOutput("reset_en", 32'(core_rx_en), 32'd0);
    cfg_enable = 1'b1;
    for (int i = 0; i < RST_CYCLES; i++) begin
      applyStimulus();
      checkOutput("rst_pulse_hi", 32'(core_rx_rst), 32'd1);
    end
    applyStimulus();
    checkOutput("run_en", 32'(core_rx_en), 32'd1);
    checkOutput("run_rst_lo", 32'(core_rx_rst), 32'd0);

    // Three characters with threshold 2, then read them back.
    irq_thresh = 3'd2;
    pushByte(8'h55, 1'b0, 1'b0);
    checkOutput("irq_below_thresh", 32'(irq), 32'd0);
    pushByte(8'hA3, 1'b0, 1'b0);
    checkOutput("irq_at_thresh", 32'(irq), 32'd1);
    pushByte(8'h0F, 1'b0, 1'b0);
    checkOutput("level3", 32'(rx_level), 32'd3);
    checkOutput("head_55", 32'(rd_data), 32'h55);
    rd_en = 1'b1; applyStimulus();
    checkOutput("head_A3", 32'(rd_data), 32'hA3);
    rd_en = 1'b1; applyStimulus();
    checkOutput("head_0F", 32'(rd_data), 32'h0F);
    rd_en = 1'b1; applyStimulus();
    checkOutput("drained_empty", 32'(rx_empty), 32'd1);
    checkOutput("drained_irq", 32'(irq), 32'd0);

    // Fill, overrun, full push with pop, clear.
    for (int i = 0; i < FIFO_DEPTH; i++) pushByte(8'(8'h10 + i), 1'b0, 1'b0);
    pushByte(8'h77, 1'b0, 1'b0);
    checkOutput("overrun_set", 32'(overrun), 32'd1);
    checkOutput("overrun_head", 32'(rd_data), 32'h10);
    err_clr = 1'b1; applyStimulus();
    pushByte(8'h77, 1'b0, 1'b1);
    checkOutput("full_push_pop_level", 32'(rx_level), 32'd4);
    checkOutput("full_push_pop_ovr", 32'(overrun), 32'd0);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      rd_en = 1'b1; applyStimulus();
    end

    // Framing error.
    pushByte(8'hFF, 1'b1, 1'b0);
    checkOutput("frame_err_set", 32'(frame_err), 32'd1);
    err_clr = 1'b1; applyStimulus();
    rd_en = 1'b1; applyStimulus();

    // Disable mid-frame: drain then idle.
    core_rx_busy = 1'b1;
    cfg_enable = 1'b0;
    applyStimulus();
    checkOutput("drain_en", 32'(core_rx_en), 32'd1);
    pushByte(8'h3C, 1'b0, 1'b0);
    checkOutput("drain_capture", 32'(rd_data), 32'h3C);
    core_rx_busy = 1'b0;
    applyStimulus();
    checkOutput("drain_idle", 32'(core_rx_en), 32'd0);
    rd_en = 1'b1; applyStimulus();

    // Flush with a coincident character.
    cfg_enable = 1'b1;
    idleCycles(RST_CYCLES + 1);
    for (int i = 0; i < 3; i++) pushByte(8'(8'hA0 + i), 1'b0, 1'b0);
    cfg_flush = 1'b1;
    pushByte(8'hEE, 1'b0, 1'b0);
    checkOutput("flush_level", 32'(rx_level), 32'd0);
    checkOutput("flush_rst", 32'(core_rx_rst), 32'd1);
    idleCycles(RST_CYCLES + 1);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) cfg_enable = ~cfg_enable;
      cfg_flush     = ($urandom_range(0, 59) == 0);
      err_clr       = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 99) == 0) irq_thresh = 3'($urandom_range(0, 4));
      if ($urandom_range(0, 5) == 0) core_rx_busy = ~core_rx_busy;
      core_rx_done  = ($urandom_range(0, 2) == 0);
      core_rx_error = ($urandom_range(0, 6) == 0);
      core_rx_data  = 8'($urandom);
      rd_en         = ($urandom_range(0, 3) == 0);
      applyStimulus();
    end

    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule
